mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data and address width.
REQ-002 Parameter: LATENCY, default 2, rising edges from issue edge to read-data capture; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch request; held high until if_ready.
REQ-006 if_addr  in  WIDTH  fetch byte address.
REQ-007 if_rdata  out  WIDTH  fetched word; registered.
REQ-008 if_ready  out  1  one-cycle completion pulse for a fetch.
REQ-009 d_req  in  1  data-access request; held high until d_ready.
REQ-010 d_we  in  1  data access is a write.
REQ-011 d_byte  in  1  byte-sized access.
REQ-012 d_addr  in  WIDTH  data byte address.
REQ-013 d_wdata  in  WIDTH  store data.
REQ-014 d_rdata  out  WIDTH  load data; registered.
REQ-015 d_ready  out  1  one-cycle completion pulse for a data access.
REQ-016 mem_en, mem_we, mem_byte  out  1 each  unified single-port memory strobes; registered.
REQ-017 mem_addr, mem_wdata  out  WIDTH each  memory address and write data; registered.
REQ-018 mem_rdata  in  WIDTH  memory read data.
REQ-019 stall  out  1  datapath hold request; combinational.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, BUSY_I and BUSY_D.
REQ-021 In IDLE, a rising edge that samples exactly one requester high SHALL grant that requester.
- Grant moves the FSM to BUSY_I (fetch) or BUSY_D (data).
- On that grant edge, the requester's address, we, byte and wdata SHALL be latched into the mem_* outputs.
- For a fetch, mem_we=0 and mem_byte=0.
REQ-022 If both if_req and d_req are sampled high in IDLE, d_req SHALL win unless the last grant was data, in which case if_req SHALL win.
REQ-023 mem_en SHALL be high for exactly the one cycle following the grant edge.
REQ-024 mem_addr, mem_we, mem_byte and mem_wdata SHALL hold stable from the grant edge until the FSM returns to IDLE.
REQ-025 A 4-bit counter SHALL be cleared on the grant edge and increment once per edge while busy.
REQ-026 On the LATENCY-th edge after the grant edge (the completion edge), the arbiter SHALL:
- for a read, capture mem_rdata into if_rdata or d_rdata;
- set the matching ready high for exactly one cycle;
- return the FSM to IDLE.
REQ-027 A data write SHALL pulse d_ready and leave d_rdata unchanged.
REQ-028 A new grant SHALL occur no earlier than the edge after the completion edge, so throughput is one transaction per LATENCY+1 cycles.
REQ-029 A requester that deasserts its req mid-transaction SHALL NOT abort the transaction; its ready SHALL still pulse.
REQ-030 Changes to request inputs while busy SHALL be ignored until IDLE.
REQ-031 stall SHALL equal (if_req AND NOT if_ready) OR (d_req AND NOT d_ready).
REQ-032 if_rdata and d_rdata SHALL hold their last captured values between transactions.

Reset
REQ-033 While rst is high, the FSM SHALL be IDLE, the counter 0, and the last-grant register set to fetch.
REQ-034 While rst is high, all registered outputs (if_rdata, d_rdata, if_ready, d_ready, mem_*) SHALL be 0.
REQ-035 A reset asserted mid-transaction SHALL abort it with no ready pulse.
REQ-036 After rst deasserts, the first arbitration edge SHALL follow the normal rules, with data winning a tie.

Verification (LATENCY=2)
REQ-037 Lone fetch: if_req=1, if_addr=0x00000010, mem_rdata=0x00A00513 ->
- mem_en high for one cycle with mem_addr=0x00000010;
- if_ready pulses once after the 2nd edge past grant;
- if_rdata=0x00A00513.
REQ-038 Store: d_req=1, d_we=1, d_byte=1, d_addr=0x00000104, d_wdata=0x000000AB ->
- mem_we=1, mem_byte=1, mem_wdata=0x000000AB;
- d_ready pulses once;
- d_rdata unchanged.
REQ-039 Tie from reset: if_req and d_req both held high ->
- grant order is data, fetch, data, fetch;
- exactly 3 cycles between successive ready pulses;
- stall stays high until both requests are dropped.
REQ-040 Dropped request: d_req deasserted one cycle after grant -> d_ready still pulses at the completion edge; FSM returns to IDLE.
REQ-041 Reset mid-flight: rst pulsed one cycle after a fetch grant -> no if_ready pulse, all outputs 0, next if_req is served normally.
REQ-042 Back-to-back loads: d_addr=0x00000200 then 0x00000204 with distinct mem_rdata values -> each value appears on d_rdata with its own d_ready pulse, in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a unified single-port memory.
// Instruction fetch and data ports share the memory; fixed read latency.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,
    input  logic             d_req,
    input  logic             d_we,
    input  logic             d_byte,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic             mem_byte,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_last_d;
    logic [WIDTH-1:0] r_if_rdata;
    logic [WIDTH-1:0] r_d_rdata;
    logic             r_if_ready;
    logic             r_d_ready;
    logic             r_mem_en;
    logic             r_mem_we;
    logic             r_mem_byte;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;

    logic w_pick_d;

    // Data wins a tie unless the previous grant already went to data.
    assign w_pick_d = d_req & (~if_req | ~r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last_d    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_mem_en   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state     <= BUSY_D;
                        r_last_d    <= 1'b1;
                        r_cnt       <= '0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_byte  <= d_byte;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (if_req) begin
                        r_state     <= BUSY_I;
                        r_last_d    <= 1'b0;
                        r_cnt       <= '0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_byte  <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    r_cnt <= r_cnt + 4'd1;
                    // Counter holds edges already seen, so LAST marks the completion edge.
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        if (r_state == BUSY_I) begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end else begin
                            r_d_ready <= 1'b1;
                            if (!r_mem_we)
                                r_d_rdata <= mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ready  = r_if_ready;
    assign d_ready   = r_d_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_byte  = r_mem_byte;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall     = (if_req & ~r_if_ready) | (d_req & ~r_d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with LATENCY=2.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         if_req;
    logic [W-1:0] if_addr;
    logic [W-1:0] if_rdata;
    logic         if_ready;
    logic         d_req;
    logic         d_we;
    logic         d_byte;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_ready;
    logic         mem_en;
    logic         mem_we;
    logic         mem_byte;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         stall;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.WIDTH(W), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0", if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({if_ready, d_ready, mem_en, mem_we, mem_byte, stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {if_ready, d_ready, mem_en, mem_we, mem_byte, stall});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: mem_en got %b expected 0", mem_en);
        end
    endtask

    task automatic test_lone_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h00A0_0513;
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_byte} !== 3'b100 || mem_addr !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL fetch_issue: got en/we/byte=%b addr=%h expected 100 addr=00000010", {mem_en, mem_we, mem_byte}, mem_addr);
        end
        n_checks++;
        if (if_ready !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_wait1: got ready=%b stall=%b expected 0 1", if_ready, stall);
        end
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0 || if_ready !== 1'b0 || mem_addr !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL fetch_wait2: got en=%b ready=%b addr=%h expected 0 0 00000010", mem_en, if_ready, mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h00A0_0513 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_done: got ready=%b rdata=%h stall=%b expected 1 00a00513 0", if_ready, if_rdata, stall);
        end
        if_req = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (if_ready !== 1'b0 || mem_en !== 1'b0 || if_rdata !== 32'h00A0_0513) begin
            n_fail++;
            $display("FAIL fetch_after: got ready=%b en=%b rdata=%h expected 0 0 00a00513", if_ready, mem_en, if_rdata);
        end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1;
        d_addr = 32'h0000_0104; d_wdata = 32'h0000_00AB; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_byte} !== 3'b111 || mem_addr !== 32'h0000_0104 || mem_wdata !== 32'h0000_00AB) begin
            n_fail++;
            $display("FAIL store_issue: got %b addr=%h wdata=%h expected 111 00000104 000000ab", {mem_en, mem_we, mem_byte}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b0 || mem_wdata !== 32'h0000_00AB || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL store_wait: got ready=%b wdata=%h we=%b expected 0 000000ab 1", d_ready, mem_wdata, mem_we);
        end
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_done: got ready=%b rdata=%h expected 1 00000000", d_ready, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b0 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_after: got ready=%b rdata=%h expected 0 00000000", d_ready, d_rdata);
        end
    endtask

    task automatic test_tie();
        logic         exp_d, exp_i, exp_en;
        logic [W-1:0] exp_addr;
        pulse_reset();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080; mem_rdata = 32'h5555_AAAA;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_d  = (k == 3) || (k == 9);
            exp_i  = (k == 6) || (k == 12);
            exp_en = (k == 1) || (k == 4) || (k == 7) || (k == 10);
            n_checks++;
            if (d_ready !== exp_d || if_ready !== exp_i || mem_en !== exp_en || stall !== 1'b1) begin
                n_fail++;
                $display("FAIL tie_cycle%0d: got d_rdy=%b i_rdy=%b en=%b stall=%b expected %b %b %b 1",
                         k, d_ready, if_ready, mem_en, stall, exp_d, exp_i, exp_en);
            end
            if (exp_en) begin
                exp_addr = ((k == 1) || (k == 7)) ? 32'h0000_0080 : 32'h0000_0040;
                n_checks++;
                if (mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL tie_grant%0d: mem_addr got %h expected %h", k, mem_addr, exp_addr);
                end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_stall_drop: got %b expected 0", stall);
        end
        @(negedge clk);
    endtask

    task automatic test_dropped_request();
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0300; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_wait: got ready=%b stall=%b expected 0 0", d_ready, stall);
        end
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL drop_done: got ready=%b rdata=%h expected 1 12345678", d_ready, d_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: got ready=%b en=%b expected 0 0", d_ready, mem_en);
        end
    endtask

    task automatic test_reset_midflight();
        int rdy_seen;
        if_req = 1'b1; if_addr = 32'h0000_0020; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL rmid_issue: got en=%b addr=%h expected 1 00000020", mem_en, mem_addr);
        end
        rst = 1'b1; if_req = 1'b0;
        #1;
        n_checks++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0 ||
            {if_ready, d_ready, mem_en, mem_we, mem_byte} !== 5'b0) begin
            n_fail++;
            $display("FAIL rmid_zero: got rdata=%h/%h addr=%h ctrl=%b expected all 0",
                     if_rdata, d_rdata, mem_addr, {if_ready, d_ready, mem_en, mem_we, mem_byte});
        end
        @(negedge clk);
        rst = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (if_ready === 1'b1) rdy_seen++;
        end
        n_checks++;
        if (rdy_seen !== 0) begin
            n_fail++;
            $display("FAIL rmid_no_ready: got %0d pulses expected 0", rdy_seen);
        end
        if_req = 1'b1; if_addr = 32'h0000_0024; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0024) begin
            n_fail++;
            $display("FAIL rmid_regrant: got en=%b addr=%h expected 1 00000024", mem_en, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rmid_done: got ready=%b rdata=%h expected 1 cafef00d", if_ready, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0200; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL b2b_first: got ready=%b rdata=%h expected 1 11111111", d_ready, d_rdata);
        end
        d_addr = 32'h0000_0204; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0204 || d_ready !== 1'b0 || d_rdata !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL b2b_second_issue: got en=%b addr=%h ready=%b rdata=%h expected 1 00000204 0 11111111",
                     mem_en, mem_addr, d_ready, d_rdata);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL b2b_second: got ready=%b rdata=%h expected 1 22222222", d_ready, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        test_reset();
        test_lone_fetch();
        test_store();
        test_tie();
        test_dropped_request();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
